// File: rtl/mon_c2sif_if.sv
// Host-side c2sif command port: four-phase req/ack with id-addressed function codes.
interface mon_c2sif_if;
  logic        c2s_req;
  logic [7:0]  c2s_id;
  logic [1:0]  c2s_fn;
  logic [31:0] c2s_wdata;
  logic        c2s_ack;
  logic [31:0] c2s_rdata;

  modport master (
    output c2s_req, c2s_id, c2s_fn, c2s_wdata,
    input  c2s_ack, c2s_rdata
  );

  modport slave (
    input  c2s_req, c2s_id, c2s_fn, c2s_wdata,
    output c2s_ack, c2s_rdata
  );
endinterface

// File: rtl/mon_c2sif.sv
// Capture monitor: synchronizes dout, timestamps every level change into a FIFO,
// and serves level/events/status to the host over the c2sif command port.
module mon_c2sif #(
  parameter int unsigned id          = 0,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dout,
  mon_c2sif_if.slave  c2s
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAITLOW} state_e;

  state_e                 state_q, state_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lvl_prev_q, lvl_prev_d;
  logic [30:0]            ts_q, ts_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   en_q, en_d;
  logic [31:0]            mem_q [DEPTH];

  logic        lvl;
  logic        edge_det;
  logic        exec;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic        do_flush;
  logic [31:0] head;
  logic [31:0] fn_result;
  logic        unused_wdata;

  assign unused_wdata = ^c2s.c2s_wdata[31:2];

  assign c2s.c2s_ack   = ack_q;
  assign c2s.c2s_rdata = rdata_q;

  assign lvl        = sync_q[SYNC_STAGES-1];
  assign edge_det   = lvl ^ lvl_prev_q;
  assign exec       = (state_q == ST_IDLE) && c2s.c2s_req && (c2s.c2s_id == 8'(id));
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // Pop is judged on the pre-cycle count, so a same-cycle pop frees room for a push.
  assign do_pop   = exec && (c2s.c2s_fn == 2'd1) && !fifo_empty;
  assign do_flush = exec && (c2s.c2s_fn == 2'd3) && c2s.c2s_wdata[1];
  assign do_push  = edge_det && en_q && !do_flush && (!fifo_full || do_pop);

  always_comb begin
    fn_result = '0;
    case (c2s.c2s_fn)
      2'd0: fn_result = {31'b0, lvl};
      2'd1: fn_result = fifo_empty ? 32'hFFFF_FFFF : head;
      2'd2: fn_result = {13'b0, lvl, en_q, ovf_q, 16'(count_q)};
      2'd3: fn_result = '0;
      default: fn_result = '0;
    endcase
  end

  // Capture path: synchronizer, edge tracking, timestamp, FIFO bookkeeping.
  always_comb begin
    ts_d       = ts_q + 31'd1;
    sync_d     = {sync_q[SYNC_STAGES-2:0], dout};
    lvl_prev_d = lvl;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    en_d       = en_q;

    if (exec && (c2s.c2s_fn == 2'd3)) begin
      en_d = c2s.c2s_wdata[0];
    end

    if (do_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
      if (edge_det && en_q && fifo_full && !do_pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Command handshake; the function executes exactly once, on the IDLE->ACK step.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (exec) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          rdata_d = fn_result;
        end
      end
      ST_ACK: begin
        if (!c2s.c2s_req) begin
          state_d = ST_WAITLOW;
          ack_d   = 1'b0;
        end
      end
      ST_WAITLOW: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      sync_q     <= '0;
      lvl_prev_q <= 1'b0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      en_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      sync_q     <= sync_d;
      lvl_prev_q <= lvl_prev_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      en_q       <= en_d;
    end
  end

  // Event storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= {lvl, ts_q};
    end
  end

endmodule

// File: doc/mon_c2sif.md
Name: mon_c2sif

Overview:
- Capture-side counterpart of the c2sif stimulus drivers.
- Samples a single DUT output (dout) and timestamps every level change.
- Buffers change events in a FIFO.
- Returns level, events and status to the host over a four-phase req/ack command port addressed by id.
- Sits in the bench between the DUT pin and the host-side c2sif channel.

Parameters:
- id, 0: command address this instance responds to (compared against c2s_id).
- DEPTH, 16: event FIFO entries; power of 2, 2..256.
- SYNC_STAGES, 2: synchronizer flops on dout; 2..4.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- dout  in  1  DUT output being monitored; asynchronous to clk.
- c2s_req  in  1  host request, four-phase.
- c2s_id  in  8  target instance id.
- c2s_fn  in  2  function code, 0..3.
- c2s_wdata  in  32  write data (fn=3 only).
- c2s_ack  out  1  acknowledge.
- c2s_rdata  out  32  read data; valid while c2s_ack=1.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - c2s_ack=0, c2s_rdata=0.
  - Synchronizer and previous-level flops = 0.
  - Timestamp counter = 0.
  - FIFO empty, overflow=0, enable=1, FSM=IDLE.
- Reset mid-handshake: c2s_ack drops immediately; the pending command is lost.
- Timestamp counter:
  - 31 bits, +1 every cycle after reset.
  - Wraps 0x7FFF_FFFF -> 0 silently.
- Synchronizer and edge detect:
  - dout passes through SYNC_STAGES flops to give lvl.
  - An edge is lvl != lvl_prev; lvl_prev is registered each cycle.
- Event push:
  - Occurs on the clock after an edge is detected, only if enable=1.
  - Entry = {lvl, ts}, where ts is the counter value in the edge-detect cycle.
  - Latency from dout change (setup met at edge k) to the entry being in the FIFO: SYNC_STAGES+1 clocks.
- FIFO full at push, with no pop in the same cycle: event dropped, overflow set (sticky).
- Push and pop in the same cycle:
  - Both take effect; pop is evaluated on the pre-cycle state.
  - Full + push + pop: no overflow, count unchanged.
  - Empty + push + pop: pop returns the empty marker, push is stored.
- Command FSM, states IDLE, ACK, WAITLOW:
  - IDLE: c2s_req=1 and c2s_id==id -> execute c2s_fn once, register c2s_rdata, go to ACK.
  - IDLE: mismatched id -> stay in IDLE, c2s_ack stays 0.
  - ACK: c2s_ack=1 from the first ACK cycle (one clock after req is seen). Stay while c2s_req=1. When c2s_req=0, go to WAITLOW and set c2s_ack=0.
  - WAITLOW: one cycle, then IDLE.
  - Minimum complete transaction = req rise, ack rise +1, req fall, ack fall +1.
  - A new req is accepted no earlier than the cycle after WAITLOW.
- c2s_rdata holds its last value until the next executed command.
- Functions:
  - fn=0 (read level): rdata = {31'b0, lvl}.
  - fn=1 (pop): rdata = head entry and the head is removed. If empty, rdata = 0xFFFF_FFFF with no state change.
  - fn=2 (status): rdata[15:0] = count (0..DEPTH), [16] = overflow, [17] = enable, [18] = lvl, rest 0.
  - fn=3 (control): enable <= wdata[0]. If wdata[1]=1, flush the FIFO and clear overflow. A flush takes priority over a same-cycle push, so that event is discarded. rdata = 0.
- Disabled (enable=0): edges are still tracked in lvl_prev (no stale event on re-enable), but nothing is pushed.

Test Plan:
- Reset release, then dout 0->1 at cycle 10 -> status count=1. Pop returns bit31=1, ts=10+SYNC_STAGES; a second pop returns 0xFFFF_FFFF.
- Toggle dout 20 times, one change every 4 cycles, DEPTH=16, no pops -> status count=16, overflow=1. 16 pops return alternating levels with ts spacing 4. fn=3 wdata=2 -> count=0, overflow=0.
- Request with c2s_id=id+1 -> c2s_ack stays 0 for 50 cycles. Request with c2s_id=id, req held 5 cycles -> ack=1 from req+1 until req fall+1, and exactly one pop is consumed.
- fn=3 wdata=0, toggle dout 3 times, fn=3 wdata=1 -> count=0; next toggle -> count=1.
- FIFO full with the pop command executing in the same cycle as an edge push -> count stays 16, overflow=0.
- Assert rst while c2s_ack=1 with 5 entries queued -> ack=0 immediately; after release, count=0 and the counter restarts at 0.
